// File: rtl/fetch_stage_pkg.sv
// Front-end constants shared by the fetch stage, its PC selector and its bench.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;
    localparam int          INST_W   = 32;

    typedef logic [INST_W-1:0] inst_t;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DISCARD
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Icache request/response bus; the fetch stage is the master, the icache the slave.
interface fetch_stage_if #(
    parameter int ADDR_W = fetch_stage_pkg::INST_W
);
    logic              inst_req_o;
    logic [ADDR_W-1:0] inst_addr_o;
    logic              inst_addr_ok_i;
    logic              inst_data_ok_i;
    logic [ADDR_W-1:0] inst_rdata_1_i;
    logic [ADDR_W-1:0] inst_rdata_2_i;

    modport master (
        output inst_req_o, inst_addr_o,
        input  inst_addr_ok_i, inst_data_ok_i, inst_rdata_1_i, inst_rdata_2_i
    );

    modport slave (
        input  inst_req_o, inst_addr_o,
        output inst_addr_ok_i, inst_data_ok_i, inst_rdata_1_i, inst_rdata_2_i
    );

endinterface

// File: rtl/fetch_stage_next_pc_sel.sv
// Next fetch PC: flush beats redirect beats sequential; sequential steps to the next 8-byte block.
module next_pc_sel #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] fetch_pc_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic              redirect_en_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              take_target_o,
    output logic [ADDR_W-1:0] next_pc_o
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        take_target_o = flush_i | redirect_en_i;
        next_pc_o     = fetch_pc_i + (fetch_pc_i[2] ? ADDR_W'(4) : ADDR_W'(8));
        if (flush_i) begin
            next_pc_o = flush_pc_i & WORD_MASK;
        end else if (redirect_en_i) begin
            next_pc_o = redirect_pc_i & WORD_MASK;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: one outstanding 8-byte icache request, up to two tagged instructions per response.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = fetch_stage_pkg::RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_pc,
    input  logic               redirect_en,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               stall,
    fetch_stage_if.master      ibus,
    output logic [ADDR_W-1:0]  inst_1_o,
    output logic [ADDR_W-1:0]  inst_2_o,
    output logic [ADDR_W-1:0]  pc_1_o,
    output logic [ADDR_W-1:0]  pc_2_o,
    output logic               inst_valid_1_o,
    output logic               inst_valid_2_o
);

    import fetch_stage_pkg::*;

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] req_pc_q;
    logic              req_en_q;
    logic              valid_1_q, valid_2_q;
    logic [ADDR_W-1:0] inst_1_q, inst_2_q, pc_1_q, pc_2_q;

    logic              take_target;
    logic [ADDR_W-1:0] next_pc;
    logic              accepted;
    logic              odd_slot;

    next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
        .fetch_pc_i    (fetch_pc_q),
        .flush_i       (flush),
        .flush_pc_i    (flush_pc),
        .redirect_en_i (redirect_en),
        .redirect_pc_i (redirect_pc),
        .take_target_o (take_target),
        .next_pc_o     (next_pc)
    );

    // stall withdraws the request combinationally; req_en_q keeps req low until the first edge out of reset.
    assign ibus.inst_req_o  = req_en_q && (state_q == S_REQ) && !stall;
    assign ibus.inst_addr_o = {fetch_pc_q[ADDR_W-1:3], 3'b000};
    assign accepted         = ibus.inst_req_o && ibus.inst_addr_ok_i;
    assign odd_slot         = req_pc_q[2];

    assign inst_1_o       = inst_1_q;
    assign inst_2_o       = inst_2_q;
    assign pc_1_o         = pc_1_q;
    assign pc_2_o         = pc_2_q;
    assign inst_valid_1_o = valid_1_q && !flush;
    assign inst_valid_2_o = valid_2_q && !flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= ADDR_W'(RESET_PC);
            req_pc_q   <= '0;
            req_en_q   <= 1'b0;
            valid_1_q  <= 1'b0;
            valid_2_q  <= 1'b0;
            inst_1_q   <= '0;
            inst_2_q   <= '0;
            pc_1_q     <= '0;
            pc_2_q     <= '0;
        end else begin
            req_en_q  <= 1'b1;
            valid_1_q <= 1'b0;
            valid_2_q <= 1'b0;

            if (take_target || (state_q == S_REQ && accepted)) begin
                fetch_pc_q <= next_pc;
            end

            case (state_q)
                S_REQ: begin
                    if (accepted) begin
                        req_pc_q <= fetch_pc_q;
                        state_q  <= take_target ? S_DISCARD : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (take_target) begin
                        state_q <= ibus.inst_data_ok_i ? S_REQ : S_DISCARD;
                    end else if (ibus.inst_data_ok_i) begin
                        valid_1_q <= 1'b1;
                        valid_2_q <= !odd_slot;
                        inst_1_q  <= odd_slot ? ibus.inst_rdata_2_i : ibus.inst_rdata_1_i;
                        pc_1_q    <= req_pc_q;
                        inst_2_q  <= odd_slot ? '0 : ibus.inst_rdata_2_i;
                        pc_2_q    <= odd_slot ? '0 : req_pc_q + ADDR_W'(4);
                        state_q   <= S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (ibus.inst_data_ok_i) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: icache agent plus transaction-level fetch model feeding a scoreboard.
module tb_fetch_stage;

    import fetch_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, redirect_en, stall;
    logic [31:0] flush_pc, redirect_pc;
    logic [31:0] inst_1_o, inst_2_o, pc_1_o, pc_2_o;
    logic        inst_valid_1_o, inst_valid_2_o;

    fetch_stage_if #(.ADDR_W(32)) ibus ();

    fetch_stage #(.RESET_PC(RST_PC), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .ibus           (ibus),
        .inst_1_o       (inst_1_o),
        .inst_2_o       (inst_2_o),
        .pc_1_o         (pc_1_o),
        .pc_2_o         (pc_2_o),
        .inst_valid_1_o (inst_valid_1_o),
        .inst_valid_2_o (inst_valid_2_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        v2;
        logic [31:0] i1, p1, i2, p2;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Fetch model: next block to fetch, and the single outstanding request (possibly stale).
    logic [31:0] m_pc, m_req_pc;
    bit          m_busy, m_stale, m_live;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFF0 | ($urandom & 32'hF);
        return 32'h1c00_0000 | ($urandom & 32'h0000_0FFF);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus, driven just after the falling edge; the model advances as of the next rising edge.
    task automatic cycle_body(input bit st, input bit fl, input logic [31:0] fpc,
                              input bit rd, input logic [31:0] rpc, input bit aok, input bit dok);
        bit          req_exp, acc, rsp, tgt_any;
        logic [31:0] tgt, base;
        exp_t        e;
        stall       = st;
        flush       = fl;
        flush_pc    = fpc;
        redirect_en = rd;
        redirect_pc = rpc;
        rsp         = m_busy && dok;
        base        = m_req_pc & ~32'h7;
        ibus.inst_data_ok_i = rsp;
        ibus.inst_rdata_1_i = rsp ? word_at(base) : $urandom;
        ibus.inst_rdata_2_i = rsp ? word_at(base + 32'h4) : $urandom;
        ibus.inst_addr_ok_i = aok;
        if (fl && sb.size() > 0 && sb[$].due == cyc) void'(sb.pop_back());
        req_exp = m_live && !m_busy && !st;
        #1;
        check("inst_req", ibus.inst_req_o, req_exp);
        if (req_exp) check("inst_addr", ibus.inst_addr_o, m_pc & ~32'h7);

        acc     = req_exp && aok;
        tgt_any = fl || rd;
        tgt     = (fl ? fpc : rpc) & ~32'h3;
        if (rsp && !m_stale && !tgt_any) begin
            e.due = cyc + 1;
            if (m_req_pc[2]) begin
                e.v2 = 1'b0; e.i1 = word_at(base + 32'h4); e.p1 = m_req_pc; e.i2 = '0; e.p2 = '0;
            end else begin
                e.v2 = 1'b1; e.i1 = word_at(base); e.p1 = m_req_pc;
                e.i2 = word_at(base + 32'h4); e.p2 = m_req_pc + 32'h4;
            end
            sb.push_back(e);
        end
        if (rsp) m_busy = 0;
        else if (m_busy && tgt_any) m_stale = 1;
        if (acc) begin
            m_busy   = 1;
            m_stale  = tgt_any;
            m_req_pc = m_pc;
        end
        if (tgt_any) m_pc = tgt;
        else if (acc) m_pc = (m_pc & ~32'h7) + 32'h8;
        m_live = 1;
    endtask

    task automatic step(input bit st, input bit fl, input logic [31:0] fpc,
                        input bit rd, input logic [31:0] rpc, input bit aok, input bit dok);
        @(negedge clk);
        cycle_body(st, fl, fpc, rd, rpc, aok, dok);
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; redirect_en = 0; flush_pc = '0; redirect_pc = '0;
        ibus.inst_addr_ok_i = 0; ibus.inst_data_ok_i = 0;
        ibus.inst_rdata_1_i = '0; ibus.inst_rdata_2_i = '0;
    endtask

    task automatic do_reset(input bit mid_cycle);
        if (mid_cycle) begin
            @(negedge clk);
            #3;
        end
        rst = 1;
        idle_inputs();
        #1;
        check("rst_req", ibus.inst_req_o, 0);
        check("rst_valid_1", inst_valid_1_o, 0);
        check("rst_valid_2", inst_valid_2_o, 0);
        check("rst_inst_1", inst_1_o, 0);
        check("rst_inst_2", inst_2_o, 0);
        check("rst_pc_1", pc_1_o, 0);
        check("rst_pc_2", pc_2_o, 0);
        sb.delete();
        m_pc = RST_PC; m_req_pc = '0; m_busy = 0; m_stale = 0; m_live = 0;
        repeat (2) @(negedge clk);
        check("rst_addr", ibus.inst_addr_o, RST_PC);
        rst = 0;
        cycle_body(0, 0, '0, 0, '0, 0, 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses a valid, after the driver has settled inputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst !== 1'b0) continue;
            while (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_pulse: got none expected pc_1 %h due cycle %0d (cycle %0d)",
                         sb[0].p1, sb[0].due, cyc);
                void'(sb.pop_front());
            end
            if (inst_valid_1_o || inst_valid_2_o) begin
                if (sb.size() == 0 || sb[0].due != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got pc_1 %h valid %b%b expected no pulse (cycle %0d)",
                             pc_1_o, inst_valid_1_o, inst_valid_2_o, cyc);
                end else begin
                    e = sb.pop_front();
                    check("valid_1", inst_valid_1_o, 1);
                    check("valid_2", inst_valid_2_o, e.v2);
                    check("inst_1", inst_1_o, e.i1);
                    check("pc_1", pc_1_o, e.p1);
                    check("inst_2", inst_2_o, e.i2);
                    check("pc_2", pc_2_o, e.p2);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1;
        idle_inputs();
        do_reset(0);

        // Free-run: addr_ok with req, data_ok one cycle later.
        step(0, 0, '0, 0, '0, 1, 0);
        step(0, 0, '0, 0, '0, 0, 1);
        step(0, 0, '0, 0, '0, 1, 0);
        step(0, 0, '0, 0, '0, 0, 1);

        // Odd redirect while waiting for acceptance.
        step(0, 0, '0, 1, 32'h1c00_0104, 0, 0);
        step(0, 0, '0, 0, '0, 1, 0);
        step(0, 0, '0, 0, '0, 0, 1);
        step(0, 0, '0, 0, '0, 1, 0);
        step(0, 0, '0, 0, '0, 0, 1);

        // Redirect mid-flight; response arrives three cycles later and is dropped.
        step(0, 0, '0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 32'h1c00_0200, 0, 0);
        step(0, 0, '0, 0, '0, 0, 0);
        step(0, 0, '0, 0, '0, 0, 0);
        step(0, 0, '0, 0, '0, 0, 1);
        step(0, 0, '0, 0, '0, 1, 0);
        step(0, 0, '0, 0, '0, 0, 1);

        // Flush and redirect together: flush wins; also a flush in the cycle of a pulse.
        step(0, 1, 32'h1c00_0800, 1, 32'h1c00_0400, 0, 0);
        step(0, 0, '0, 0, '0, 1, 0);
        step(0, 0, '0, 0, '0, 0, 1);
        step(0, 1, 32'h1c00_0a00, 0, '0, 0, 0);

        // Stall for five cycles with a response in flight.
        step(0, 0, '0, 0, '0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, '0, 0, '0, 1, i == 1);
        step(0, 0, '0, 0, '0, 0, 0);
        step(0, 0, '0, 0, '0, 1, 0);
        step(0, 0, '0, 0, '0, 0, 1);

        // Wrap at the top of the address space, then an odd target that wraps via +4.
        step(0, 0, '0, 1, 32'hFFFF_FFF8, 0, 0);
        step(0, 0, '0, 0, '0, 1, 0);
        step(0, 0, '0, 0, '0, 0, 1);
        step(0, 0, '0, 1, 32'hFFFF_FFFE, 1, 0);
        step(0, 0, '0, 0, '0, 0, 1);
        step(0, 0, '0, 0, '0, 1, 0);
        step(0, 0, '0, 0, '0, 0, 1);
        step(0, 0, '0, 0, '0, 1, 0);
        step(0, 0, '0, 0, '0, 0, 1);

        // Async reset between edges while a request is outstanding and outputs hold data.
        step(0, 0, '0, 0, '0, 1, 0);
        step(0, 0, '0, 0, '0, 0, 1);
        step(0, 0, '0, 0, '0, 1, 0);
        do_reset(1);
        step(0, 0, '0, 0, '0, 1, 0);
        step(0, 0, '0, 0, '0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 4) == 0,
                 $urandom_range(0, 24) == 0, rand_pc(),
                 $urandom_range(0, 15) == 0, rand_pc(),
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 1) == 1);
        end

        // Drain any outstanding request without issuing new ones.
        repeat (8) step(0, 0, '0, 0, '0, 0, 1);
        repeat (2) @(negedge clk);
        #3;
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
